// File: rtl/key_event_queue.sv
// ============================================================================
// key_event_queue: 14-key edge detector feeding a show-ahead event FIFO.
// Optional typematic repeat when KEY_AUTOREPEAT_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module key_event_queue #(
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic [13:0]                   key_in,
  output logic [5:0]                    evt_code,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow
);

  localparam int KEY_N = 14;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
`ifdef KEY_AUTOREPEAT_EN
  localparam int MEM_W = 6;
`else
  localparam int MEM_W = 5;
`endif

  generate
    if (FIFO_DEPTH < 4 || FIFO_DEPTH > 32 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("key_event_queue: invalid parameter value");
    end
  endgenerate

  logic [KEY_N-1:0] prev_q, prev_d;
  logic [KEY_N-1:0] pend_p_q, pend_p_d;
  logic [KEY_N-1:0] pend_r_q, pend_r_d;
  logic             overflow_q, overflow_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [MEM_W-1:0] mem_q [FIFO_DEPTH];

  logic [KEY_N-1:0] rise, fall, pend_any, clr_p, clr_r;
  logic [3:0]       sel_idx;
  logic             sel_pr, sel_press, have_evt, push, pop, full;
  logic [MEM_W-1:0] new_code;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [31:0] DELAY_M1  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] PERIOD_M1 = 32'(REPEAT_PERIOD - 1);

  logic        rep_active_q, rep_active_d;
  logic [3:0]  rep_idx_q, rep_idx_d;
  logic [31:0] rep_timer_q, rep_timer_d;
  logic        rep_first_q, rep_first_d;
  logic        pend_rep_q, pend_rep_d;
  logic        rep_fire;
  logic [3:0]  rise_idx;
`endif

  always_comb begin
    rise     = key_in & ~prev_q;
    fall     = ~key_in & prev_q;
    prev_d   = key_in;
    pend_any = pend_p_q | pend_r_q;

    // Lowest index wins; within one key a press precedes its release.
    sel_idx = 4'd0;
    for (int i = KEY_N - 1; i >= 0; i--) begin
      if (pend_any[i]) sel_idx = 4'(i);
    end
    sel_pr    = |pend_any;
    sel_press = pend_p_q[sel_idx];
    have_evt  = sel_pr;
    new_code  = MEM_W'({sel_press, sel_idx});
`ifdef KEY_AUTOREPEAT_EN
    if (!sel_pr && pend_rep_q) begin
      have_evt = 1'b1;
      new_code = {2'b11, rep_idx_q};
    end
`endif

    pop  = (count_q != '0) && evt_ready;
    full = (count_q == CW'(FIFO_DEPTH));
    push = have_evt && (!full || pop);

    clr_p = (push && sel_pr && sel_press)  ? (14'(1) << sel_idx) : '0;
    clr_r = (push && sel_pr && !sel_press) ? (14'(1) << sel_idx) : '0;

    pend_p_d   = (pend_p_q | rise) & ~clr_p;
    pend_r_d   = (pend_r_q | fall) & ~clr_r;
    overflow_d = overflow_q | (|(rise & pend_p_q)) | (|(fall & pend_r_q));

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

`ifdef KEY_AUTOREPEAT_EN
    rise_idx = 4'd0;
    for (int i = KEY_N - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = 4'(i);
    end
    rep_active_d = rep_active_q;
    rep_idx_d    = rep_idx_q;
    rep_timer_d  = rep_timer_q;
    rep_first_d  = rep_first_q;
    rep_fire     = 1'b0;
    pend_rep_d   = pend_rep_q && !(push && !sel_pr);
    if (|rise) begin
      rep_active_d = 1'b1;
      rep_idx_d    = rise_idx;
      rep_timer_d  = '0;
      rep_first_d  = 1'b1;
      pend_rep_d   = 1'b0;
    end else if (rep_active_q) begin
      if (fall[rep_idx_q]) begin
        rep_active_d = 1'b0;
        pend_rep_d   = 1'b0;
      end else if (rep_timer_q == (rep_first_q ? DELAY_M1 : PERIOD_M1)) begin
        rep_timer_d = '0;
        rep_first_d = 1'b0;
        rep_fire    = 1'b1;
        pend_rep_d  = 1'b1;
      end else begin
        rep_timer_d = rep_timer_q + 32'd1;
      end
    end
    overflow_d = overflow_d | (rep_fire & pend_rep_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      prev_q       <= key_in;
      pend_p_q     <= '0;
      pend_r_q     <= '0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
`ifdef KEY_AUTOREPEAT_EN
      rep_active_q <= 1'b0;
      rep_idx_q    <= 4'd0;
      rep_timer_q  <= '0;
      rep_first_q  <= 1'b0;
      pend_rep_q   <= 1'b0;
`endif
    end else begin
      prev_q       <= prev_d;
      pend_p_q     <= pend_p_d;
      pend_r_q     <= pend_r_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
`ifdef KEY_AUTOREPEAT_EN
      rep_active_q <= rep_active_d;
      rep_idx_q    <= rep_idx_d;
      rep_timer_q  <= rep_timer_d;
      rep_first_q  <= rep_first_d;
      pend_rep_q   <= pend_rep_d;
`endif
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_code;
  end

  always_comb begin
`ifdef KEY_AUTOREPEAT_EN
    evt_code = mem_q[rd_ptr_q];
`else
    evt_code = {1'b0, mem_q[rd_ptr_q]};
`endif
    evt_valid = (count_q != '0);
    evt_count = count_q;
    overflow  = overflow_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_key_event_queue.sv
// ============================================================================
// tb_key_event_queue: directed self-checking bench for key_event_queue. Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_event_queue;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [13:0] key_in = '0;
  logic [5:0]  evt_code;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [3:0]  evt_count;
  logic        overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  key_event_queue #(
    .FIFO_DEPTH    (8),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (4)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .key_in    (key_in),
    .evt_code  (evt_code),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0; key_in = '0; evt_ready = 1'b0;
    tick(2);
    clrn = 1'b1;
    total_cnt++;
    if (evt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", evt_valid); else pass_cnt++;
    total_cnt++;
    if (evt_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", evt_count); else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else pass_cnt++;
  endtask

  task automatic test_single();
    evt_ready = 1'b1;
    key_in = 14'h0002;
    tick(1);
    total_cnt++;
    if (evt_valid !== 1'b0) $display("FAIL single_latency: valid got %b want 0", evt_valid); else pass_cnt++;
    tick(1);
    total_cnt++;
    if (evt_valid !== 1'b1 || evt_code !== 6'h11)
      $display("FAIL single_press: valid %b code %h want 1 11", evt_valid, evt_code);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (evt_valid !== 1'b0) $display("FAIL single_pop: valid got %b want 0", evt_valid); else pass_cnt++;
    key_in = 14'h0000;
    tick(2);
    total_cnt++;
    if (evt_valid !== 1'b1 || evt_code !== 6'h01)
      $display("FAIL single_release: valid %b code %h want 1 01", evt_valid, evt_code);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (evt_valid !== 1'b0) $display("FAIL single_empty: valid got %b want 0", evt_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_q [6] = '{6'h10, 6'h16, 6'h1D, 6'h00, 6'h06, 6'h0D};
    evt_ready = 1'b1;
    key_in = 14'h2041;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (evt_valid !== 1'b1 || evt_code !== exp_q[k])
        $display("FAIL b2b_press[%0d]: valid %b code %h want 1 %h", k, evt_valid, evt_code, exp_q[k]);
      else pass_cnt++;
      tick(1);
    end
    total_cnt++;
    if (evt_valid !== 1'b0) $display("FAIL b2b_gap: valid got %b want 0", evt_valid); else pass_cnt++;
    key_in = 14'h0000;
    tick(2);
    for (int k = 3; k < 6; k++) begin
      total_cnt++;
      if (evt_valid !== 1'b1 || evt_code !== exp_q[k])
        $display("FAIL b2b_release[%0d]: valid %b code %h want 1 %h", k, evt_valid, evt_code, exp_q[k]);
      else pass_cnt++;
      tick(1);
    end
  endtask

  task automatic test_full_drain();
    logic [5:0] exp_q [10] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h14,
                               6'h00, 6'h01, 6'h02, 6'h03, 6'h04};
    evt_ready = 1'b0;
    key_in = 14'h001F;
    tick(6);
    key_in = 14'h0000;
    tick(6);
    total_cnt++;
    if (evt_count !== 4'd8) $display("FAIL full_count: got %0d want 8", evt_count); else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL full_no_overflow: got %b want 0", overflow); else pass_cnt++;
    evt_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      total_cnt++;
      if (evt_valid !== 1'b1 || evt_code !== exp_q[k])
        $display("FAIL drain[%0d]: valid %b code %h want 1 %h", k, evt_valid, evt_code, exp_q[k]);
      else pass_cnt++;
      tick(1);
    end
    total_cnt++;
    if (evt_valid !== 1'b0 || evt_count !== 4'd0)
      $display("FAIL drain_empty: valid %b count %0d want 0 0", evt_valid, evt_count);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    key_in = 14'h01FE;
    tick(10);
    total_cnt++;
    if (evt_count !== 4'd8 || overflow !== 1'b0)
      $display("FAIL ovf_prefill: count %0d ovf %b want 8 0", evt_count, overflow);
    else pass_cnt++;
    key_in = 14'h01FF; tick(1);
    key_in = 14'h01FE; tick(1);
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", overflow); else pass_cnt++;
    key_in = 14'h01FF; tick(1);
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else pass_cnt++;
    tick(5);
    total_cnt++;
    if (overflow !== 1'b1 || evt_count !== 4'd8)
      $display("FAIL ovf_sticky: ovf %b count %0d want 1 8", overflow, evt_count);
    else pass_cnt++;
    key_in = 14'h0000;
    clrn = 1'b0; tick(1);
    clrn = 1'b1; tick(1);
    total_cnt++;
    if (overflow !== 1'b0 || evt_valid !== 1'b0)
      $display("FAIL ovf_clear: ovf %b valid %b want 0 0", overflow, evt_valid);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    evt_ready = 1'b0;
    key_in = 14'h0079;
    tick(6);
    total_cnt++;
    if (evt_count !== 4'd5) $display("FAIL midrst_prefill: count %0d want 5", evt_count); else pass_cnt++;
    clrn = 1'b0; tick(1);
    clrn = 1'b1;
    total_cnt++;
    if (evt_count !== 4'd0 || overflow !== 1'b0)
      $display("FAIL midrst_clear: count %0d ovf %b want 0 0", evt_count, overflow);
    else pass_cnt++;
    tick(4);
    total_cnt++;
    if (evt_valid !== 1'b0) $display("FAIL midrst_no_press: valid got %b want 0", evt_valid); else pass_cnt++;
    key_in = 14'h0000;
    tick(7);
    total_cnt++;
    if (evt_count !== 4'd5 || evt_code !== 6'h00)
      $display("FAIL midrst_release: count %0d code %h want 5 00", evt_count, evt_code);
    else pass_cnt++;
    clrn = 1'b0; tick(1);
    clrn = 1'b1;
  endtask

`ifdef KEY_AUTOREPEAT_EN
  task automatic test_repeat();
    logic       exp_v;
    logic [5:0] exp_c;
    evt_ready = 1'b1;
    key_in = 14'h0004;
    for (int c = 1; c <= 45; c++) begin
      tick(1);
      exp_v = 1'b0;
      exp_c = 6'h00;
      if (c == 2) begin
        exp_v = 1'b1; exp_c = 6'h12;
      end else if (c >= 12 && c <= 32 && ((c - 12) % 4) == 0) begin
        exp_v = 1'b1; exp_c = 6'h32;
      end else if (c == 33) begin
        exp_v = 1'b1; exp_c = 6'h02;
      end
      total_cnt++;
      if (evt_valid !== exp_v || (exp_v && evt_code !== exp_c))
        $display("FAIL repeat[%0d]: valid %b code %h want %b %h", c, evt_valid, evt_code, exp_v, exp_c);
      else pass_cnt++;
      if (c == 31) key_in = 14'h0000;
    end
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL repeat_overflow: got %b want 0", overflow); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_drain();
    test_overflow();
    test_mid_reset();
`ifdef KEY_AUTOREPEAT_EN
    test_repeat();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
